pipe_buffer: RTL and testbench

Parametrised, handshaked pipeline-stage buffer that generalises the fixed always-load stage registers between the MIPS pipeline stages. It carries one WIDTH-bit payload with valid/ready flow control, supports stall and flush, and holds a two-entry skid buffer so that `in_ready` is driven from a register. One instance sits at each stage boundary; the payload is the concatenated stage bundle, for example target, alu, valB, dest, op and signals.

---
 rtl/pipe_buffer.sv | 100 ++++++++++
 tb/tb_pipe_buffer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_buffer.sv
// rtl/pipe_buffer.sv - handshaked pipeline-stage buffer with two-entry skid, optional PIPE_BUFFER_STALL_CNT_EN counter
module pipe_buffer #(
    parameter int unsigned     WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned     CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_BUFFER_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_count,
`endif
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    // Handshake outputs decode only the state register, never in_valid/out_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_data;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q  <= in_data;
                        state_q <= TWO;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_BUFFER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Deliberately unaffected by flush; only reset clears the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_buffer.sv
// tb/tb_pipe_buffer.sv - directed self-checking bench for pipe_buffer
module tb_pipe_buffer;

    localparam int unsigned WIDTH = 8;
    localparam logic [7:0]  RV    = 8'h5A;
    localparam int unsigned CNT_W = 4;

    logic             clock;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_BUFFER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    pipe_buffer #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .CNT_W       (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef PIPE_BUFFER_STALL_CNT_EN
        .stall_count (stall_count),
`endif
        .out_data    (out_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic r, input logic [7:0] d);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".in_ready"},  32'(in_ready),  32'(r));
        check({tag, ".out_data"},  32'(out_data),  32'(d));
    endtask

    task automatic expect_cnt(input string tag, input int unsigned c);
`ifdef PIPE_BUFFER_STALL_CNT_EN
        check({tag, ".stall_count"}, 32'(stall_count), 32'(c));
`else
        if (c > 32'hFFFF) $display("bad count argument %0d for %s", c, tag);
`endif
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clock);
        expect_out("rst", 1'b0, 1'b1, RV);
        expect_cnt("rst", 0);
        reset = 1'b1;
        @(negedge clock);
        expect_out("idle", 1'b0, 1'b1, RV);

        // Streaming 1,2,3 with out_ready held high
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        @(negedge clock); expect_out("s1", 1'b1, 1'b1, 8'h01); in_data = 8'h02;
        @(negedge clock); expect_out("s2", 1'b1, 1'b1, 8'h02); in_data = 8'h03;
        @(negedge clock); expect_out("s3", 1'b1, 1'b1, 8'h03); in_valid = 1'b0;
        @(negedge clock); expect_out("s_drain", 1'b0, 1'b1, 8'h03);
        expect_cnt("s_drain", 0);

        // Backpressure: A, B fill both entries, C held off
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
        @(negedge clock); expect_out("bpA", 1'b1, 1'b1, 8'h0A); in_data = 8'h0B;
        @(negedge clock); expect_out("bpTWO", 1'b1, 1'b0, 8'h0A); in_data = 8'h0C;
        @(negedge clock); expect_out("bpHold", 1'b1, 1'b0, 8'h0A);
        expect_cnt("bpHold", 2);
        out_ready = 1'b1;
        @(negedge clock); expect_out("bpB", 1'b1, 1'b1, 8'h0B);
        @(negedge clock); expect_out("bpC", 1'b1, 1'b1, 8'h0C); in_valid = 1'b0;
        @(negedge clock); expect_out("bpDrain", 1'b0, 1'b1, 8'h0C);
        expect_cnt("bpDrain", 2);

        // Flush while TWO is held and 0xD is offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        @(negedge clock); in_data = 8'h22;
        @(negedge clock); expect_out("flTWO", 1'b1, 1'b0, 8'h11);
        flush = 1'b1; in_data = 8'h0D;
        @(negedge clock); expect_out("flush", 1'b0, 1'b1, 8'h11);
        expect_cnt("flush", 4);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clock); expect_out("flAfter", 1'b0, 1'b1, 8'h11);

        // Stall counter saturation
        in_valid = 1'b1; in_data = 8'h33;
        @(negedge clock); in_valid = 1'b0;
        expect_out("satLoad", 1'b1, 1'b1, 8'h33);
        repeat (5) @(negedge clock);
        expect_cnt("sat9", 9);
        repeat (15) @(negedge clock);
        expect_cnt("sat15", 15);
        flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        expect_out("satFlush", 1'b0, 1'b1, 8'h33);
        expect_cnt("satFlush", 15);

        // Asynchronous reset between edges while in TWO
        in_valid = 1'b1; in_data = 8'h44;
        @(negedge clock); in_data = 8'h55;
        @(negedge clock); in_valid = 1'b0;
        expect_out("arTWO", 1'b1, 1'b0, 8'h44);
        #2 reset = 1'b0;
        #1;
        expect_out("arAsync", 1'b0, 1'b1, RV);
        expect_cnt("arAsync", 0);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); expect_out("arIdle", 1'b0, 1'b1, RV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
